gray_ptr_rx: RTL and testbench
==============================

GRAY_PTR_RX -- requirements
Module: gray_ptr_rx

Interface
REQ-001 The block SHALL have parameter SIZE, default 4, giving the pointer width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port gray_in, input, SIZE bits: gray-coded write pointer from a remote producer, asynchronous to clk.
REQ-005 The block SHALL have port rd_inc, input, 1 bit: the local consumer's request to advance the read pointer by one.
REQ-006 The block SHALL have port bin_out, output, SIZE bits: the synchronized and decoded binary write pointer.
REQ-007 The block SHALL have port rd_ptr, output, SIZE bits: the local binary read pointer.
REQ-008 The block SHALL have port avail, output, SIZE bits: entries available, (bin_out - rd_ptr) mod 2^SIZE.
REQ-009 The block SHALL have port empty, output, 1 bit: high when avail == 0.
REQ-010 The block SHALL have port rd_fire, output, 1 bit: high when rd_inc is accepted in the current cycle.
REQ-011 The block SHALL have port upd, output, 1 bit: a one-cycle pulse when bin_out changes value.
REQ-012 The block SHALL have port gray_err, output, 1 bit: sticky flag indicating an illegal multi-bit gray transition.

Function
REQ-013 gray_in SHALL pass through two synchronizer flops (s1, s2) before any other use.
REQ-014 A history register s3 SHALL hold the previous value of s2.
REQ-015 bin_out SHALL be registered from the gray-to-binary decode of s2, so a gray_in change appears on bin_out on the 3rd rising edge after it is sampled.
REQ-016 The decode SHALL be: bin[SIZE-1] = g[SIZE-1]; bin[i] = bin[i+1] XOR g[i], for i descending.
REQ-017 avail SHALL be combinational from bin_out and rd_ptr, with modulo-2^SIZE subtraction and the result truncated to SIZE bits.
REQ-018 empty SHALL be combinational: asserted iff bin_out == rd_ptr.
REQ-019 rd_fire SHALL equal rd_inc AND NOT empty.
REQ-020 rd_inc while empty SHALL be ignored, with no pointer change and no error.
REQ-021 On rd_fire, rd_ptr SHALL increment by 1 at the next edge, wrapping 2^SIZE-1 -> 0.
REQ-022 rd_fire SHALL be the only cause of an rd_ptr change.
REQ-023 upd SHALL be registered, high for exactly the cycle in which bin_out first holds a new value.
REQ-024 gray_err SHALL be set at the edge after popcount(s2 XOR s3) > 1 is observed.
REQ-025 Once set, gray_err SHALL remain high until reset.
REQ-026 A multi-bit gray transition SHALL still be decoded and forwarded to bin_out; gray_err only flags it.
REQ-027 If rd_fire and an upd-causing change occur in the same cycle, both SHALL take effect, and avail SHALL reflect both updated registers on the next cycle.
REQ-028 The block SHALL NOT detect overflow; with bin_out == rd_ptr the block SHALL report empty.

Reset
REQ-029 While rst is low, s1, s2, s3, bin_out, and rd_ptr SHALL be 0 asynchronously.
REQ-030 While rst is low, upd and gray_err SHALL be 0, which makes empty = 1, avail = 0, and rd_fire = 0.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight synchronizer contents.
REQ-032 After rst deassertion, the first valid bin_out update SHALL follow the 3-edge latency of REQ-015.

Structure
REQ-033 A shared package gray_pkg SHALL hold the functions gray2bin and bin2gray and the default-width constant GRAY_SIZE = 4.
REQ-034 The block SHALL use exactly one sub-module, sync2 (a parameterized two-flop synchronizer with asynchronous active-low reset), for s1/s2.
REQ-035 The decode and popcount logic SHALL be local combinational logic; no additional sub-modules are required.

Verification (SIZE=4)
REQ-036 Reset: rst low with arbitrary gray_in=1011 -> all outputs 0, empty=1; after release, bin_out=1101 3 edges later, with upd pulsing once.
REQ-037 Counting: gray_in 0000->0001->0011->0010, each held 4 cycles -> bin_out 0,1,2,3, each 3 edges after the change; upd pulses 3 times; gray_err stays 0.
REQ-038 Drain: gray_in=0110 (bin 4), rd_inc held high 6 cycles from rd_ptr=0 -> rd_fire high 4 cycles; rd_ptr steps 1..4; avail 4,3,2,1,0; empty then 1; rd_ptr holds at 4.
REQ-039 Wrap: rd_ptr=14, gray_in 1000 (15) -> 0000 (0) -> avail 1 then 2; two rd_fire -> rd_ptr 15 then 0; empty=1.
REQ-040 Error: gray_in 0000 -> 0101 -> bin_out=0110, gray_err=1 one edge after s2 shows the change; gray_err holds through later legal steps until rst.
REQ-041 Simultaneity and mid-run reset: rd_fire in the same cycle as upd -> avail is consistent next cycle; rst pulsed low mid-stream -> immediate return to REQ-029 and REQ-030 values.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared gray-code helpers and width constants for the gray pointer receiver.
// Functions work on a wide vector so any pointer width up to GRAY_MAXW can use them.
package gray_pkg;

    localparam int GRAY_SIZE = 4;
    localparam int GRAY_MAXW = 32;

    typedef logic [GRAY_MAXW-1:0] gray_w_t;

    // Leading zeros decode to zeros, so narrower pointers can be zero-extended in
    // and truncated back out.
    function automatic gray_w_t gray2bin(input gray_w_t g);
        gray_w_t b;
        b[GRAY_MAXW-1] = g[GRAY_MAXW-1];
        for (int i = GRAY_MAXW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic gray_w_t bin2gray(input gray_w_t b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a multi-bit gray-coded bus.
// Ports: clk, rst_n (async active-low), d_i (async input), q_o (synchronized output).
module sync2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/gray_ptr_rx.sv
// Receive side of a gray-coded pointer crossing: synchronizes a remote write
// pointer, decodes it, tracks a local read pointer and flags illegal gray steps.
// Ports: clk, rst (async active-low), gray_in (remote gray pointer), rd_inc
// (advance request); bin_out, rd_ptr, avail, empty, rd_fire, upd, gray_err.
module gray_ptr_rx
    import gray_pkg::*;
#(
    parameter int SIZE = GRAY_SIZE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] gray_in,
    input  logic            rd_inc,
    output logic [SIZE-1:0] bin_out,
    output logic [SIZE-1:0] rd_ptr,
    output logic [SIZE-1:0] avail,
    output logic            empty,
    output logic            rd_fire,
    output logic            upd,
    output logic            gray_err
);

    logic [SIZE-1:0] s2;
    logic [SIZE-1:0] s3_q;
    logic [SIZE-1:0] bin_q;
    logic [SIZE-1:0] bin_d;
    logic [SIZE-1:0] rd_q;
    logic [SIZE-1:0] rd_d;
    logic [SIZE-1:0] diff;
    logic            multi;
    logic            fire;
    logic            upd_q;
    logic            upd_d;
    logic            err_q;
    logic            err_d;

    sync2 #(
        .W(SIZE)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst),
        .d_i  (gray_in),
        .q_o  (s2)
    );

    always_comb begin
        bin_d = SIZE'(gray2bin(GRAY_MAXW'(s2)));
        diff  = s2 ^ s3_q;
        // Clearing the lowest set bit leaves something only if two or more
        // bits flipped, i.e. popcount(diff) > 1.
        multi = |(diff & (diff - SIZE'(1)));
        fire  = rd_inc & (bin_q != rd_q);
        rd_d  = fire ? rd_q + SIZE'(1) : rd_q;
        upd_d = (bin_d != bin_q);
        err_d = err_q | multi;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s3_q  <= '0;
            bin_q <= '0;
            rd_q  <= '0;
            upd_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            s3_q  <= s2;
            bin_q <= bin_d;
            rd_q  <= rd_d;
            upd_q <= upd_d;
            err_q <= err_d;
        end
    end

    assign bin_out  = bin_q;
    assign rd_ptr   = rd_q;
    assign avail    = bin_q - rd_q;
    assign empty    = (bin_q == rd_q);
    assign rd_fire  = fire;
    assign upd      = upd_q;
    assign gray_err = err_q;

endmodule

// File: tb/tb_gray_ptr_rx.sv
// Directed bench for gray_ptr_rx (SIZE=4): cycle table for counting, drain and
// simultaneity, plus hand sequences for reset, wrap, gray errors and mid-run reset.
module tb_gray_ptr_rx;

    logic       clk;
    logic       rst;
    logic [3:0] gray_in;
    logic       rd_inc;
    logic [3:0] bin_out;
    logic [3:0] rd_ptr;
    logic [3:0] avail;
    logic       empty;
    logic       rd_fire;
    logic       upd;
    logic       gray_err;

    int errs   = 0;
    int checks = 0;

    gray_ptr_rx #(
        .SIZE(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .gray_in (gray_in),
        .rd_inc  (rd_inc),
        .bin_out (bin_out),
        .rd_ptr  (rd_ptr),
        .avail   (avail),
        .empty   (empty),
        .rd_fire (rd_fire),
        .upd     (upd),
        .gray_err(gray_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] g;
        logic       inc;
        logic [3:0] bin;
        logic [3:0] rd;
        logic [3:0] av;
        logic       e;
        logic       f;
        logic       u;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int n, input logic [3:0] g, input logic inc,
                       input logic [3:0] bin, input logic [3:0] rd,
                       input logic [3:0] av, input logic e, input logic f,
                       input logic u);
        vec_t v;
        v.g = g; v.inc = inc; v.bin = bin; v.rd = rd;
        v.av = av; v.e = e; v.f = f; v.u = u;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic [3:0] g);
        rst = 1'b0;
        gray_in = g;
        rd_inc = 1'b0;
        tick(2);
        rst = 1'b1;
    endtask

    function automatic logic [3:0] b2g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    int pulses;

    initial begin
        rst = 1'b0;
        gray_in = 4'b1011;
        rd_inc = 1'b1;
        #3;
        chk("rst.bin", bin_out, 0);
        chk("rst.rd", rd_ptr, 0);
        chk("rst.avail", avail, 0);
        chk("rst.empty", empty, 1);
        chk("rst.fire", rd_fire, 0);
        chk("rst.upd", upd, 0);
        chk("rst.err", gray_err, 0);
        rd_inc = 1'b0;
        tick(2);
        chk("rst.hold_bin", bin_out, 0);
        rst = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            #1;
            if (k == 2) chk("rel.bin_e2", bin_out, 0);
            if (k == 3) chk("rel.bin_e3", bin_out, 13);
            if (upd) pulses++;
        end
        chk("rel.upd_pulses", pulses, 1);

        // Counting, drain, and rd_fire coinciding with a pointer update.
        add(4, 4'd0, 0, 0, 0, 0, 1, 0, 0);
        add(3, 4'd1, 0, 0, 0, 0, 1, 0, 0);
        add(1, 4'd1, 0, 1, 0, 1, 0, 0, 1);
        add(3, 4'd3, 0, 1, 0, 1, 0, 0, 0);
        add(1, 4'd3, 0, 2, 0, 2, 0, 0, 1);
        add(3, 4'd2, 0, 2, 0, 2, 0, 0, 0);
        add(1, 4'd2, 0, 3, 0, 3, 0, 0, 1);
        add(4, 4'd2, 0, 3, 0, 3, 0, 0, 0);
        add(3, 4'd6, 0, 3, 0, 3, 0, 0, 0);
        add(1, 4'd6, 0, 4, 0, 4, 0, 0, 1);
        add(1, 4'd6, 1, 4, 0, 4, 0, 1, 0);
        add(1, 4'd6, 1, 4, 1, 3, 0, 1, 0);
        add(1, 4'd6, 1, 4, 2, 2, 0, 1, 0);
        add(1, 4'd6, 1, 4, 3, 1, 0, 1, 0);
        add(2, 4'd6, 1, 4, 4, 0, 1, 0, 0);
        add(1, 4'd6, 0, 4, 4, 0, 1, 0, 0);
        add(2, 4'd7, 0, 4, 4, 0, 1, 0, 0);
        add(1, 4'd5, 0, 4, 4, 0, 1, 0, 0);
        add(1, 4'd5, 0, 5, 4, 1, 0, 0, 1);
        add(1, 4'd5, 1, 5, 4, 1, 0, 1, 0);
        add(1, 4'd5, 0, 6, 5, 1, 0, 0, 1);
        add(1, 4'd5, 0, 6, 5, 1, 0, 0, 0);

        do_reset(4'd0);
        foreach (tbl[i]) begin
            gray_in = tbl[i].g;
            rd_inc  = tbl[i].inc;
            #1;
            chk($sformatf("v%0d.bin", i), bin_out, tbl[i].bin);
            chk($sformatf("v%0d.rd", i), rd_ptr, tbl[i].rd);
            chk($sformatf("v%0d.avail", i), avail, tbl[i].av);
            chk($sformatf("v%0d.empty", i), empty, tbl[i].e);
            chk($sformatf("v%0d.fire", i), rd_fire, tbl[i].f);
            chk($sformatf("v%0d.upd", i), upd, tbl[i].u);
            chk($sformatf("v%0d.err", i), gray_err, 0);
            tick(1);
        end

        // Wrap of the read pointer through 15 -> 0.
        do_reset(4'd0);
        for (int b = 0; b <= 14; b++) begin
            gray_in = b2g(4'(b));
            tick(1);
        end
        tick(3);
        #1;
        chk("wrap.bin14", bin_out, 14);
        rd_inc = 1'b1;
        tick(14);
        rd_inc = 1'b0;
        #1;
        chk("wrap.rd14", rd_ptr, 14);
        chk("wrap.empty14", empty, 1);
        gray_in = 4'b1000;
        tick(3);
        #1;
        chk("wrap.avail1", avail, 1);
        gray_in = 4'b0000;
        tick(3);
        #1;
        chk("wrap.bin0", bin_out, 0);
        chk("wrap.avail2", avail, 2);
        rd_inc = 1'b1;
        #1;
        chk("wrap.fire", rd_fire, 1);
        tick(1);
        #1;
        chk("wrap.rd15", rd_ptr, 15);
        tick(1);
        rd_inc = 1'b0;
        #1;
        chk("wrap.rd0", rd_ptr, 0);
        chk("wrap.empty", empty, 1);
        chk("wrap.err", gray_err, 0);

        // Illegal two-bit gray step, sticky error, then mid-run reset.
        do_reset(4'd0);
        gray_in = 4'b0101;
        tick(2);
        #1;
        chk("err.pre", gray_err, 0);
        chk("err.pre_bin", bin_out, 0);
        tick(1);
        #1;
        chk("err.set", gray_err, 1);
        chk("err.bin6", bin_out, 6);
        gray_in = 4'b0100;
        tick(4);
        #1;
        chk("err.bin7", bin_out, 7);
        chk("err.sticky", gray_err, 1);
        gray_in = 4'b1100;
        tick(1);
        rst = 1'b0;
        rd_inc = 1'b1;
        #1;
        chk("mid.bin", bin_out, 0);
        chk("mid.rd", rd_ptr, 0);
        chk("mid.avail", avail, 0);
        chk("mid.empty", empty, 1);
        chk("mid.fire", rd_fire, 0);
        chk("mid.upd", upd, 0);
        chk("mid.err", gray_err, 0);
        rd_inc = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(2);
        #1;
        chk("mid.flush_bin", bin_out, 0);
        tick(1);
        #1;
        chk("mid.bin8", bin_out, 8);
        chk("mid.upd8", upd, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
